// File: rtl/maze_pkg.sv
// maze_pkg: shared constants for the maze game core.
//   - direction key indices
//   - map count
//   - the two 8x8 wall maps; bit c of row r set means cell (r,c) is a wall
//   - per-map start and terminal cells
//   - wall_row(): wall bits of one row of the selected map
package maze_pkg;

  localparam int NUM_DIRS    = 4;
  localparam int DIR_ROW_INC = 0;
  localparam int DIR_ROW_DEC = 1;
  localparam int DIR_COL_DEC = 2;
  localparam int DIR_COL_INC = 3;

  localparam int NUM_MAPS = 2;

  localparam logic [7:0] MAP0 [0:7] = '{
    8'b0001_1110,
    8'b0100_0010,
    8'b0101_0100,
    8'b0001_0001,
    8'b0110_0100,
    8'b0000_1010,
    8'b0100_0000,
    8'b0001_0000
  };

  localparam logic [7:0] MAP1 [0:7] = '{
    8'b1000_0001,
    8'b0011_1100,
    8'b1000_0010,
    8'b1010_0000,
    8'b1000_1000,
    8'b1011_0000,
    8'b1000_0110,
    8'b1000_0001
  };

  localparam logic [2:0] START_ROW [0:1] = '{3'd6, 3'd7};
  localparam logic [2:0] START_COL [0:1] = '{3'd7, 3'd6};
  localparam logic [2:0] TERM_ROW  [0:1] = '{3'd0, 3'd1};
  localparam logic [2:0] TERM_COL  [0:1] = '{3'd0, 3'd7};

  function automatic logic [7:0] wall_row(input logic map_id, input logic [2:0] r);
    return map_id ? MAP1[r] : MAP0[r];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: single-key debouncer with press pulse.
//   clk   system clock
//   rst   synchronous reset, active-low
//   key   raw key, active-high
//   press one-cycle pulse on the rising edge of the debounced level
// The debounced level rises once DEB_CNT consecutive high samples have been
// seen and drops in the same cycle the raw key reads 0.
module key_debounce #(
  parameter int DEB_CNT = 4194303
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             lvl_q;
  logic             lvl_d_q;
  logic             level;

  // gating with the raw key makes a release visible without a cycle of lag
  assign level = lvl_q & key;
  assign press = level & ~lvl_d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= CNT_LOAD;
      lvl_q   <= 1'b0;
      lvl_d_q <= 1'b0;
    end else begin
      lvl_d_q <= level;
      if (!key) begin
        cnt_q <= CNT_LOAD;
        lvl_q <= 1'b0;
      end else if (cnt_q == '0) begin
        lvl_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_engine.sv
// maze_engine: maze game core driving a row-scanned red/green dot matrix.
//   clk        system clock
//   rst        synchronous reset, active-low
//   start      raw start key; a press loads the map chosen by map_sel
//   map_sel    map choice, sampled on a start press
//   direction  raw move keys: [0] row+1, [1] row-1, [2] col-1, [3] col+1
//   row        active-low one-hot row strobe, bits >= GRID held 1
//   g_col      green columns (player, terminal)
//   r_col      red columns (walls, terminal)
//   pos_row/pos_col  player cell
//   steps      accepted moves since start, saturating
//   win        player has reached the terminal cell
// Build option: MAZE_BLINK_EN blinks the player (and the whole green plane
// after a win), toggling every 256 scan ticks.
module maze_engine
  import maze_pkg::*;
#(
  parameter int GRID     = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 4194303,
  parameter int STEP_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      map_sel,
  input  logic [3:0]                direction,
  output logic [7:0]                row,
  output logic [7:0]                g_col,
  output logic [7:0]                r_col,
  output logic [$clog2(GRID)-1:0]   pos_row,
  output logic [$clog2(GRID)-1:0]   pos_col,
  output logic [STEP_W-1:0]         steps,
  output logic                      win
);

  localparam int CW = $clog2(GRID);
  localparam logic [CW-1:0] LAST = CW'(GRID - 1);
  localparam logic [7:0] COL_MASK = 8'((9'd1 << GRID) - 9'd1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);

  logic [3:0]        dir_press;
  logic              start_press;

  logic              map_q;
  logic [CW-1:0]     pos_row_q, pos_col_q;
  logic [STEP_W-1:0] steps_q;
  logic              win_q;

  logic [DIV_W-1:0]  scan_div_q;
  logic [CW-1:0]     scan_idx_q;
  logic [7:0]        row_q, g_q, r_q;

  genvar k;
  generate
    for (k = 0; k < NUM_DIRS; k++) begin : g_dir_deb
      key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .key   (direction[k]),
        .press (dir_press[k])
      );
    end
  endgenerate

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_start (
    .clk   (clk),
    .rst   (rst),
    .key   (start),
    .press (start_press)
  );

  // ---------------- move evaluation ----------------
  logic          mv_req, mv_off, mv_ok, at_term;
  logic [CW-1:0] t_row, t_col;
  logic [7:0]    t_walls;

  always_comb begin
    mv_req = (|dir_press) & ~win_q & ~start_press;
    mv_off = 1'b0;
    t_row  = pos_row_q;
    t_col  = pos_col_q;
    if (dir_press[DIR_ROW_INC]) begin
      if (pos_row_q == LAST) mv_off = 1'b1;
      else                   t_row  = pos_row_q + 1'b1;
    end else if (dir_press[DIR_ROW_DEC]) begin
      if (pos_row_q == '0)   mv_off = 1'b1;
      else                   t_row  = pos_row_q - 1'b1;
    end else if (dir_press[DIR_COL_DEC]) begin
      if (pos_col_q == '0)   mv_off = 1'b1;
      else                   t_col  = pos_col_q - 1'b1;
    end else if (dir_press[DIR_COL_INC]) begin
      if (pos_col_q == LAST) mv_off = 1'b1;
      else                   t_col  = pos_col_q + 1'b1;
    end
    t_walls = wall_row(map_q, 3'(t_row)) & COL_MASK;
    mv_ok   = mv_req & ~mv_off & ~t_walls[3'(t_col)];
    at_term = (pos_row_q == CW'(TERM_ROW[map_q])) &&
              (pos_col_q == CW'(TERM_COL[map_q]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      map_q     <= 1'b0;
      pos_row_q <= CW'(START_ROW[0]);
      pos_col_q <= CW'(START_COL[0]);
      steps_q   <= '0;
      win_q     <= 1'b0;
    end else if (start_press) begin
      map_q     <= map_sel;
      pos_row_q <= CW'(START_ROW[map_sel]);
      pos_col_q <= CW'(START_COL[map_sel]);
      steps_q   <= '0;
      win_q     <= 1'b0;
    end else begin
      if (mv_ok) begin
        pos_row_q <= t_row;
        pos_col_q <= t_col;
        if (steps_q != '1) steps_q <= steps_q + 1'b1;
      end
      if (!win_q && at_term) win_q <= 1'b1;
    end
  end

  // ---------------- display scan ----------------
  logic          scan_tick;
  logic [CW-1:0] nxt_idx;
  logic [7:0]    term_bits, player_bits, row_nxt, red_nxt, green_nxt;
  logic          blink_on;

`ifdef MAZE_BLINK_EN
  logic [7:0] blink_cnt_q;
  logic       blink_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= 8'hFF;
      blink_q     <= 1'b1;
    end else if (scan_tick) begin
      if (blink_cnt_q == 8'h00) begin
        blink_cnt_q <= 8'hFF;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q - 1'b1;
      end
    end
  end

  assign blink_on = blink_q;
`else
  assign blink_on = 1'b1;
`endif

  always_comb begin
    scan_tick   = (scan_div_q == '0);
    nxt_idx     = (scan_idx_q == LAST) ? '0 : scan_idx_q + 1'b1;
    term_bits   = (CW'(TERM_ROW[map_q]) == nxt_idx) ? (8'd1 << TERM_COL[map_q]) : 8'd0;
    player_bits = (pos_row_q == nxt_idx) ? (8'd1 << pos_col_q) : 8'd0;
    row_nxt     = ~(8'd1 << nxt_idx);
    red_nxt     = (wall_row(map_q, 3'(nxt_idx)) & COL_MASK) | term_bits;
    // after a win the blink gates the whole green plane, otherwise only the player
    if (win_q) green_nxt = (player_bits | term_bits) & {8{blink_on}};
    else       green_nxt = term_bits | (player_bits & {8{blink_on}});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_div_q <= '0;
      scan_idx_q <= '0;
      row_q      <= 8'hFF;
      g_q        <= 8'h00;
      r_q        <= 8'h00;
    end else if (scan_tick) begin
      scan_div_q <= DIV_LOAD;
      scan_idx_q <= nxt_idx;
      row_q      <= row_nxt;
      g_q        <= green_nxt;
      r_q        <= red_nxt;
    end else begin
      scan_div_q <= scan_div_q - 1'b1;
    end
  end

  assign row     = row_q;
  assign g_col   = g_q;
  assign r_col   = r_q;
  assign pos_row = pos_row_q;
  assign pos_col = pos_col_q;
  assign steps   = steps_q;
  assign win     = win_q;

endmodule

// File: tb/tb_maze_engine.sv
module tb_maze_engine;

  localparam int GRID     = 8;
  localparam int SCAN_DIV = 3;
  localparam int DEB_CNT  = 4;
  localparam int STEP_W   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       map_sel = 1'b0;
  logic [3:0] direction = 4'h0;
  logic [7:0] row, g_col, r_col;
  logic [2:0] pos_row, pos_col;
  logic [7:0] steps;
  logic       win;

  always #5 clk = ~clk;

  maze_engine #(
    .GRID(GRID), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .map_sel(map_sel), .direction(direction),
    .row(row), .g_col(g_col), .r_col(r_col),
    .pos_row(pos_row), .pos_col(pos_col), .steps(steps), .win(win)
  );

  int passed = 0;
  int total  = 0;

  // reference maze: bit c of walls[m][r] set = wall at (r,c)
  logic [7:0] walls [2][8] = '{
    '{8'b0001_1110, 8'b0100_0010, 8'b0101_0100, 8'b0001_0001,
      8'b0110_0100, 8'b0000_1010, 8'b0100_0000, 8'b0001_0000},
    '{8'b1000_0001, 8'b0011_1100, 8'b1000_0010, 8'b1010_0000,
      8'b1000_1000, 8'b1011_0000, 8'b1000_0110, 8'b1000_0001}
  };
  int srow [2] = '{6, 7};
  int scol [2] = '{7, 6};
  int trow [2] = '{0, 1};
  int tcol [2] = '{0, 7};

  int m_map, m_r, m_c, m_steps;
  bit m_win;

  function automatic void model_start(int sel);
    m_map = sel; m_r = srow[sel]; m_c = scol[sel]; m_steps = 0; m_win = 0;
  endfunction

  function automatic void model_move(logic [3:0] d);
    int nr, nc;
    if (m_win || d == 4'h0) return;
    nr = m_r; nc = m_c;
    if (d[0]) nr++;
    else if (d[1]) nr--;
    else if (d[2]) nc--;
    else nc++;
    if (nr < 0 || nr >= GRID || nc < 0 || nc >= GRID) return;
    if (walls[m_map][nr][nc]) return;
    m_r = nr; m_c = nc;
    if (m_steps < (1 << STEP_W) - 1) m_steps++;
    if (m_r == trow[m_map] && m_c == tcol[m_map]) m_win = 1;
  endfunction

  function automatic logic [14:0] exp_state();
    return {3'(m_r), 3'(m_c), 8'(m_steps), m_win};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // hold keys for 'hold' sampling edges, release, let things settle
  task automatic press(logic [3:0] d, logic s, logic ms, int hold);
    direction = d; start = s; map_sel = ms;
    cyc(hold);
    direction = 4'h0; start = 1'b0;
    cyc(3);
    if (hold > DEB_CNT) begin
      if (s) model_start(int'(ms));
      else   model_move(d);
    end
  endtask

  task automatic test_reset();
    int waited;
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    model_start(0);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL reset_state got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
    total++;
    if ({row, g_col, r_col} !== {8'hFF, 8'h00, 8'h00})
      $display("FAIL reset_display got %h want %h", {row, g_col, r_col}, {8'hFF, 8'h00, 8'h00});
    else passed++;
    waited = 0;
    while (row === 8'hFF && waited < 2 * SCAN_DIV) begin cyc(1); waited++; end
    total++;
    if (row === 8'hFF)
      $display("FAIL first_tick row still %h after %0d cycles", row, waited);
    else passed++;
  endtask

  task automatic test_wall_and_single_move();
    press(4'b0100, 1'b0, 1'b0, 50);
    total++;
    if ({pos_row, pos_col, steps, win} !== {3'd6, 3'd7, 8'd0, 1'b0})
      $display("FAIL wall_block got %h want %h", {pos_row, pos_col, steps, win}, {3'd6, 3'd7, 8'd0, 1'b0});
    else passed++;
    press(4'b0010, 1'b0, 1'b0, 50);
    total++;
    if ({pos_row, pos_col, steps, win} !== {3'd5, 3'd7, 8'd1, 1'b0})
      $display("FAIL single_move got %h want %h", {pos_row, pos_col, steps, win}, {3'd5, 3'd7, 8'd1, 1'b0});
    else passed++;
  endtask

  task automatic test_offgrid_and_short_pulse();
    press(4'b0001, 1'b0, 1'b0, 8);
    press(4'b1000, 1'b0, 1'b0, 8);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL offgrid got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
    press(4'b0001, 1'b0, 1'b0, DEB_CNT - 1);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL short_pulse got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
  endtask

  task automatic test_priority();
    press(4'b0101, 1'b0, 1'b0, 8);
    total++;
    if ({pos_row, pos_col, steps, win} !== {3'd7, 3'd7, 8'd3, 1'b0})
      $display("FAIL priority got %h want %h", {pos_row, pos_col, steps, win}, {3'd7, 3'd7, 8'd3, 1'b0});
    else passed++;
  endtask

  task automatic test_start_mid_hold();
    direction = 4'b0100; map_sel = 1'b0;
    cyc(10);
    model_move(4'b0100);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL hold_move got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
    start = 1'b1;
    cyc(10);
    direction = 4'h0; start = 1'b0;
    cyc(3);
    model_start(0);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL start_mid_hold got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
  endtask

  task automatic test_win();
    bit arrived;
    press(4'b0000, 1'b1, 1'b1, DEB_CNT + 2);
    total++;
    if ({pos_row, pos_col, steps, win} !== {3'd7, 3'd6, 8'd0, 1'b0})
      $display("FAIL map1_start got %h want %h", {pos_row, pos_col, steps, win}, {3'd7, 3'd6, 8'd0, 1'b0});
    else passed++;
    for (int i = 0; i < 6; i++) press(4'b0010, 1'b0, 1'b1, DEB_CNT + 1);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL win_path got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
    direction = 4'b1000;
    arrived = 0;
    for (int t = 0; t < 20 && !arrived; t++) begin
      cyc(1);
      if (pos_row === 3'd1 && pos_col === 3'd7) begin
        arrived = 1;
        total++;
        if (win !== 1'b0) $display("FAIL win_early got %b want 0", win);
        else passed++;
        cyc(1);
        total++;
        if (win !== 1'b1) $display("FAIL win_next_cycle got %b want 1", win);
        else passed++;
      end
    end
    if (!arrived) begin
      total++;
      $display("FAIL win_arrival timeout pos %0d,%0d want 1,7", pos_row, pos_col);
    end
    direction = 4'h0;
    cyc(3);
    model_move(4'b1000);
    press(4'b0100, 1'b0, 1'b1, 8);
    press(4'b0010, 1'b0, 1'b1, 8);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL win_frozen got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
    press(4'b0000, 1'b1, 1'b1, 8);
    total++;
    if ({pos_row, pos_col, steps, win} !== {3'd7, 3'd6, 8'd0, 1'b0})
      $display("FAIL win_clear got %h want %h", {pos_row, pos_col, steps, win}, {3'd7, 3'd6, 8'd0, 1'b0});
    else passed++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 130; i++) begin
      press(4'b0010, 1'b0, 1'b1, DEB_CNT + 1);
      press(4'b0001, 1'b0, 1'b1, DEB_CNT + 1);
    end
    total++;
    if (steps !== 8'hFF || {pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL steps_saturate got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
  endtask

  task automatic test_random();
    int hold;
    for (int i = 0; i < 40; i++) begin
      hold = int'($urandom_range(1, 8));
      if (hold == DEB_CNT) hold++;
      if (m_win || $urandom_range(0, 9) == 0)
        press(4'b0000, 1'b1, 1'($urandom_range(0, 1)), DEB_CNT + 2);
      else
        press(4'($urandom_range(1, 15)), 1'b0, 1'b0, hold);
      total++;
      if ({pos_row, pos_col, steps, win} !== exp_state())
        $display("FAIL random_%0d got %h want %h", i, {pos_row, pos_col, steps, win}, exp_state());
      else passed++;
    end
  endtask

  task automatic test_scan();
    int waited, per, i;
    logic [7:0] prev, exp_r, exp_g;
    press(4'b0000, 1'b1, 1'b0, DEB_CNT + 2);
    waited = 0;
    while (row === 8'hFE && waited < 4 * SCAN_DIV) begin cyc(1); waited++; end
    while (row !== 8'hFE && waited < (GRID + 4) * SCAN_DIV) begin cyc(1); waited++; end
    total++;
    if (row !== 8'hFE) $display("FAIL scan_sync row %h want fe", row);
    else passed++;
    for (int k = 0; k <= GRID; k++) begin
      i = k % GRID;
      if (k > 0) begin
        prev = row; per = 0;
        while (row === prev && per < 3 * SCAN_DIV) begin cyc(1); per++; end
        total++;
        if (per != SCAN_DIV) $display("FAIL scan_period tick %0d got %0d want %0d", k, per, SCAN_DIV);
        else passed++;
      end
      exp_r = walls[m_map][i];
      exp_g = (i == m_r) ? (8'd1 << m_c) : 8'd0;
      if (i == trow[m_map]) begin
        exp_r |= 8'd1 << tcol[m_map];
        exp_g |= 8'd1 << tcol[m_map];
      end
      total++;
      if (row !== ~(8'd1 << i)) $display("FAIL scan_row tick %0d got %h want %h", k, row, ~(8'd1 << i));
      else passed++;
      total++;
      if (r_col !== exp_r) $display("FAIL scan_red tick %0d got %h want %h", k, r_col, exp_r);
      else passed++;
      total++;
      if (g_col !== exp_g) $display("FAIL scan_green tick %0d got %h want %h", k, g_col, exp_g);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_scan();
    press(4'b0000, 1'b1, 1'b1, DEB_CNT + 2);
    press(4'b0010, 1'b0, 1'b1, DEB_CNT + 2);
    cyc(SCAN_DIV + 1);
    rst = 1'b0;
    cyc(1);
    model_start(0);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL reset_mid_state got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
    total++;
    if ({row, g_col, r_col} !== {8'hFF, 8'h00, 8'h00})
      $display("FAIL reset_mid_display got %h want %h", {row, g_col, r_col}, {8'hFF, 8'h00, 8'h00});
    else passed++;
    rst = 1'b1;
    // (6,6) is a wall only in map 0, so this shows the active map returned to 0
    press(4'b0100, 1'b0, 1'b0, DEB_CNT + 2);
    total++;
    if ({pos_row, pos_col, steps, win} !== exp_state())
      $display("FAIL reset_map got %h want %h", {pos_row, pos_col, steps, win}, exp_state());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_wall_and_single_move();
    test_offgrid_and_short_pulse();
    test_priority();
    test_start_mid_hold();
    test_win();
    test_saturate();
    test_random();
    test_scan();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog timeout after %0d/%0d checks", passed, total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maze_engine.md
Name: maze_engine

Overview:
- Parametrised maze game core for the LED matrix board: debounced start key plus four direction keys move a player cell across a wall map.
- Tracks step count and goal arrival, and drives a row-scanned red/green dot matrix (red = walls, green = player, both = terminal).
- Successor of the single-map position tracker. Adds:
  - wall collision
  - one move per key press
  - two selectable maps
  - step counter and win flag
  - synchronous reset
  - clock-enable scan in place of a derived clock

Parameters:
- GRID, 8, matrix side length in cells (2..8); row/col index width CW = $clog2(GRID).
- SCAN_DIV, 50000, clk cycles per display row advance.
- DEB_CNT, 4194303, consecutive high cycles before a key counts as pressed.
- STEP_W, 8, step counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  raw start key, active-high.
- map_sel  in  1  map choice, sampled on a start press.
- direction  in  4  raw keys:
  - [0] row+1
  - [1] row-1
  - [2] col-1
  - [3] col+1
- row  out  8  active-low one-hot row strobe; bits ≥ GRID held 1.
- g_col  out  8  active-high green columns.
- r_col  out  8  active-high red columns.
- pos_row  out  CW  player row.
- pos_col  out  CW  player col.
- steps  out  STEP_W  accepted moves since start.
- win  out  1  player on terminal cell.

Behaviour:
- Reset (rst=0 at posedge clk):
  - pos = map0 start (6,7)
  - steps = 0, win = 0, active map = 0
  - scan index = 0, scan divider = 0
  - row = 8'hFF, g_col = 0, r_col = 0
  - debouncers cleared
  - Reset overrides every other event in the same cycle.
- Debounce:
  - Each of the 5 keys is debounced independently.
  - The level output rises after DEB_CNT consecutive high samples and clears in the same cycle the raw key reads 0.
  - An action fires on the rising edge of a debounced level: exactly one per press, regardless of hold time.
- Start press:
  - active map ← map_sel
  - pos ← that map's start cell
  - steps ← 0, win ← 0
  - Any move edge in the same cycle is ignored.
- Move press (win=0):
  - If several edges coincide, priority is [0]>[1]>[2]>[3].
  - The target cell is computed; the move is rejected if the target is off-grid (row/col <0 or >GRID-1) or a wall bit is set there.
  - Accepted: pos updates next cycle and steps increments, saturating at all-ones.
  - Rejected: no change.
- Win:
  - win ← 1 in the cycle after pos equals the terminal cell.
  - While win=1, all moves are ignored; only start or reset clears win.
- Scan:
  - Divider issues a 1-cycle tick every SCAN_DIV clks.
  - On a tick, scan index wraps GRID-1→0, else increments.
  - On the cycle after the tick, for the new index i:
    - row = ~(1<<i)
    - r_col = wall row i | terminal bit if terminal in row i
    - g_col = player bit if pos_row==i | terminal bit
  - Display uses the pos value current at the tick.
  - No derived clocks anywhere.
- Maps:
  - Cell (r,c) is a wall if map[r][c]=1.
  - Map bits at indices ≥ GRID are ignored.
  - Start/terminal cells are never walls.

Optional Feature:
- MAZE_BLINK_EN defined:
  - The green player bit is gated by a blink toggle that flips every 256 scan ticks.
  - After win, the whole green plane blinks at the same rate.
- Undefined: player shown steadily and no blink logic is present.
- Blinking never affects pos, steps or win.

Decomposition:
- Package maze_pkg holds:
  - direction index constants
  - map count
  - the two 8x8 wall maps as constant arrays; map0 row 6 = 8'b0100_0000
  - start/terminal constants:
    - map0: start (6,7), terminal (0,0)
    - map1: start (7,6), terminal (1,7)
- Sub-module key_debounce (parameter DEB_CNT) is instantiated 5×.

Test Plan:
- DEB_CNT=4, SCAN_DIV=3; release reset → pos=(6,7), steps=0, win=0, row=8'hFF until the first tick.
- Hold direction[2] for 50 cycles → target (6,6) is a wall: pos stays (6,7), steps=0. Hold direction[1] 50 cycles → pos=(5,7), steps=1 (single move).
- At pos (6,7), press direction[3] → col 8 off-grid: rejected, steps unchanged. Pulse direction[0] for 3 cycles → ignored (below DEB_CNT).
- Press direction[0] and [2] in the same cycle → row move wins: pos row+1, steps+1. Press start mid-hold of a direction → pos returns to start, steps=0, no extra move.
- map_sel=1, press start → pos=(7,6). Drive a path to (1,7) → win=1 the cycle after arrival; further presses leave pos/steps frozen; start clears win.
- Watch 9 ticks → row sequence FE,FD,…,7F,FE; g_col has the player bit only on the player's row; the terminal row shows the terminal bit in both r_col and g_col. Assert rst=0 mid-scan → all outputs return to reset values on the next edge.
